sys_ctrl_rx: RTL and testbench



---
 rtl/sys_ctrl_pkg.sv | 28 ++
 rtl/sys_ctrl_rx_if.sv | 36 +++
 rtl/sys_ctrl_rx.sv | 189 ++++++++++++++++++
 tb/tb_sys_ctrl_rx.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller (receive and transmit halves).
// Command byte codes, reserved operand addresses and the receive FSM states.
package sys_ctrl_pkg;

    // Command bytes that open a frame
    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // Register-file locations that hold the ALU operands
    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    // Receive-side FSM states (binary encoded)
    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_WR_ADDR  = 4'd1;
    localparam state_t ST_WR_DATA  = 4'd2;
    localparam state_t ST_RD_ADDR  = 4'd3;
    localparam state_t ST_RD_WAIT  = 4'd4;
    localparam state_t ST_ALU_OPA  = 4'd5;
    localparam state_t ST_ALU_OPB  = 4'd6;
    localparam state_t ST_ALU_FUN  = 4'd7;
    localparam state_t ST_ALU_WAIT = 4'd8;

endpackage

// File: rtl/sys_ctrl_rx_if.sv
// Bus bundle between the receive-side controller and its surroundings:
// UART byte input, response strobes, register-file and ALU request outputs.
interface sys_ctrl_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
);
    // Inbound byte stream and responses
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  Rd_data_valid;
    logic                  ALU_OUT_valid;

    // Register-file / ALU requests
    logic [ADDR_WIDTH-1:0] Address;
    logic                  WrEn;
    logic                  RdEn;
    logic [DATA_WIDTH-1:0] WrData;
    logic                  ALU_EN;
    logic [FUN_WIDTH-1:0]  ALU_FUN;
    logic                  CLK_GATE_EN;
    logic                  Cmd_err;

    // The controller itself
    modport slave (
        input  RX_P_DATA, RX_D_VLD, Rd_data_valid, ALU_OUT_valid,
        output Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, Cmd_err
    );

    // Whatever feeds the controller and consumes its requests
    modport master (
        output RX_P_DATA, RX_D_VLD, Rd_data_valid, ALU_OUT_valid,
        input  Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, Cmd_err
    );

endinterface

// File: rtl/sys_ctrl_rx.sv
// Command-side system controller: decodes UART command frames into
// register-file write/read requests and ALU starts, then waits (bounded by
// TIMEOUT cycles) for the read-data or ALU-result response.
module sys_ctrl_rx
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic          CLK,
    input  logic          rst,
    sys_ctrl_rx_if.slave  bus
);

    // Counter only ever needs to reach TIMEOUT
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                state_reg,       state_next;
    logic [ADDR_WIDTH-1:0] wr_addr_reg,     wr_addr_next;
    logic [CNT_W-1:0]      cnt_reg,         cnt_next;
    logic [ADDR_WIDTH-1:0] address_reg,     address_next;
    logic [DATA_WIDTH-1:0] wr_data_reg,     wr_data_next;
    logic [FUN_WIDTH-1:0]  alu_fun_reg,     alu_fun_next;
    logic                  clk_gate_en_reg, clk_gate_en_next;
    logic                  wr_en_reg,       wr_en_next;
    logic                  rd_en_reg,       rd_en_next;
    logic                  alu_en_reg,      alu_en_next;
    logic                  cmd_err_reg,     cmd_err_next;

    logic [CNT_W-1:0]      cnt_inc;
    logic                  timeout_hit;
    logic                  resp;

    // Wait-state bookkeeping: cycles spent waiting including this one
    assign cnt_inc     = cnt_reg + 1'b1;
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

    // Next-state and next-output decode; strobes default low, data holds
    always_comb begin
        state_next       = state_reg;
        wr_addr_next     = wr_addr_reg;
        cnt_next         = cnt_reg;
        address_next     = address_reg;
        wr_data_next     = wr_data_reg;
        alu_fun_next     = alu_fun_reg;
        clk_gate_en_next = clk_gate_en_reg;
        wr_en_next       = 1'b0;
        rd_en_next       = 1'b0;
        alu_en_next      = 1'b0;
        cmd_err_next     = 1'b0;
        resp             = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.RX_D_VLD) begin
                    case (bus.RX_P_DATA)
                        DATA_WIDTH'(CMD_WR):  state_next = ST_WR_ADDR;
                        DATA_WIDTH'(CMD_RD):  state_next = ST_RD_ADDR;
                        DATA_WIDTH'(CMD_ALU_OP): begin
                            state_next       = ST_ALU_OPA;
                            clk_gate_en_next = 1'b1;
                        end
                        DATA_WIDTH'(CMD_ALU_NOP): begin
                            state_next       = ST_ALU_FUN;
                            clk_gate_en_next = 1'b1;
                        end
                        default: cmd_err_next = 1'b1;
                    endcase
                end
            end

            ST_WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    wr_addr_next = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    state_next   = ST_WR_DATA;
                end
            end

            ST_WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    wr_en_next   = 1'b1;
                    address_next = wr_addr_reg;
                    wr_data_next = bus.RX_P_DATA;
                    state_next   = ST_IDLE;
                end
            end

            ST_RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    rd_en_next   = 1'b1;
                    address_next = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    cnt_next     = '0;
                    state_next   = ST_RD_WAIT;
                end
            end

            ST_ALU_OPA: begin
                if (bus.RX_D_VLD) begin
                    wr_en_next   = 1'b1;
                    address_next = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_next = bus.RX_P_DATA;
                    state_next   = ST_ALU_OPB;
                end
            end

            ST_ALU_OPB: begin
                if (bus.RX_D_VLD) begin
                    wr_en_next   = 1'b1;
                    address_next = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_next = bus.RX_P_DATA;
                    state_next   = ST_ALU_FUN;
                end
            end

            ST_ALU_FUN: begin
                if (bus.RX_D_VLD) begin
                    alu_fun_next = bus.RX_P_DATA[FUN_WIDTH-1:0];
                    alu_en_next  = 1'b1;
                    cnt_next     = '0;
                    state_next   = ST_ALU_WAIT;
                end
            end

            // Both wait states share the same rules; only the response differs.
            // A response beats both a coincident byte and the timeout cycle.
            ST_RD_WAIT, ST_ALU_WAIT: begin
                resp     = (state_reg == ST_RD_WAIT) ? bus.Rd_data_valid
                                                     : bus.ALU_OUT_valid;
                cnt_next = cnt_inc;
                if (resp) begin
                    cmd_err_next = bus.RX_D_VLD;
                    if (state_reg == ST_ALU_WAIT) begin
                        clk_gate_en_next = 1'b0;
                    end
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    cmd_err_next     = 1'b1;
                    clk_gate_en_next = 1'b0;
                    state_next       = ST_IDLE;
                end else begin
                    cmd_err_next = bus.RX_D_VLD;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any partial frame
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            wr_addr_reg     <= '0;
            cnt_reg         <= '0;
            address_reg     <= '0;
            wr_data_reg     <= '0;
            alu_fun_reg     <= '0;
            clk_gate_en_reg <= 1'b0;
            wr_en_reg       <= 1'b0;
            rd_en_reg       <= 1'b0;
            alu_en_reg      <= 1'b0;
            cmd_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wr_addr_reg     <= wr_addr_next;
            cnt_reg         <= cnt_next;
            address_reg     <= address_next;
            wr_data_reg     <= wr_data_next;
            alu_fun_reg     <= alu_fun_next;
            clk_gate_en_reg <= clk_gate_en_next;
            wr_en_reg       <= wr_en_next;
            rd_en_reg       <= rd_en_next;
            alu_en_reg      <= alu_en_next;
            cmd_err_reg     <= cmd_err_next;
        end
    end

    assign bus.Address     = address_reg;
    assign bus.WrEn        = wr_en_reg;
    assign bus.RdEn        = rd_en_reg;
    assign bus.WrData      = wr_data_reg;
    assign bus.ALU_EN      = alu_en_reg;
    assign bus.ALU_FUN     = alu_fun_reg;
    assign bus.CLK_GATE_EN = clk_gate_en_reg;
    assign bus.Cmd_err     = cmd_err_reg;

endmodule

// File: tb/tb_sys_ctrl_rx.sv
// Bench for sys_ctrl_rx: directed vector table, multi-cycle corner cases
// (timeout, response on the timeout cycle, async reset) and random traffic
// against a frame-level reference model.
module tb_sys_ctrl_rx;
    import sys_ctrl_pkg::*;

    localparam int TIMEOUT = 255;

    logic CLK = 1'b0;
    logic rst;
    always #5 CLK = ~CLK;

    sys_ctrl_rx_if bus ();

    sys_ctrl_rx #(.TIMEOUT(TIMEOUT)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic       ae;
        logic       err;
        logic [3:0] addr;
        logic [7:0] wd;
        logic [3:0] fun;
        logic       gate;
    } outs_t;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       rdv;
        logic       aluv;
        outs_t      exp;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl[$];

    function automatic outs_t mk(logic wr, logic rd, logic ae, logic err,
                                 logic [3:0] addr, logic [7:0] wd,
                                 logic [3:0] fun, logic gate);
        outs_t o;
        o.wr = wr; o.rd = rd; o.ae = ae; o.err = err;
        o.addr = addr; o.wd = wd; o.fun = fun; o.gate = gate;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.wr = bus.WrEn; o.rd = bus.RdEn; o.ae = bus.ALU_EN; o.err = bus.Cmd_err;
        o.addr = bus.Address; o.wd = bus.WrData; o.fun = bus.ALU_FUN;
        o.gate = bus.CLK_GATE_EN;
        return o;
    endfunction

    function automatic string fmt(outs_t o);
        return $sformatf("wr=%0b rd=%0b alu_en=%0b err=%0b addr=%h wdata=%h fun=%h gate=%0b",
                         o.wr, o.rd, o.ae, o.err, o.addr, o.wd, o.fun, o.gate);
    endfunction

    task automatic check(string name, outs_t exp);
        outs_t act;
        act = sample();
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got [%s] expected [%s]", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs; return 1ns after the edge that consumed them
    task automatic step(logic v, logic [7:0] d, logic r, logic a);
        bus.RX_D_VLD      = v;
        bus.RX_P_DATA     = d;
        bus.Rd_data_valid = r;
        bus.ALU_OUT_valid = a;
        @(posedge CLK);
        #1;
    endtask

    task automatic add(logic v, logic [7:0] d, logic r, logic a, outs_t e);
        vec_t t;
        t.vld = v; t.data = d; t.rdv = r; t.aluv = a; t.exp = e;
        tbl.push_back(t);
    endtask

    // Reference model: bytes collected per frame, action chosen by the
    // opening command and the byte's position in the frame.
    outs_t      m;
    int         wait_kind;   // 0 none, 1 read response, 2 ALU response
    int         waited;
    logic [7:0] fq[$];

    task automatic model_reset();
        m = '0;
        wait_kind = 0;
        waited = 0;
        fq.delete();
    endtask

    task automatic model_step(logic v, logic [7:0] d, logic r, logic a);
        logic [7:0] cmd, b;
        m.wr = 1'b0; m.rd = 1'b0; m.ae = 1'b0; m.err = 1'b0;
        if (wait_kind != 0) begin
            waited++;
            if ((wait_kind == 1 && r) || (wait_kind == 2 && a)) begin
                if (wait_kind == 2) m.gate = 1'b0;
                m.err = v;
                wait_kind = 0;
            end else if (waited == TIMEOUT) begin
                m.err = 1'b1;
                m.gate = 1'b0;
                wait_kind = 0;
            end else begin
                m.err = v;
            end
        end else if (v) begin
            fq.push_back(d);
            cmd = fq[0];
            b = d;
            if (cmd == CMD_WR) begin
                if (fq.size() == 3) begin
                    b = fq[1];
                    m.wr = 1'b1; m.addr = b[3:0]; m.wd = fq[2];
                    fq.delete();
                end
            end else if (cmd == CMD_RD) begin
                if (fq.size() == 2) begin
                    m.rd = 1'b1; m.addr = b[3:0];
                    wait_kind = 1; waited = 0;
                    fq.delete();
                end
            end else if (cmd == CMD_ALU_OP) begin
                case (fq.size())
                    1: m.gate = 1'b1;
                    2: begin m.wr = 1'b1; m.addr = 4'd0; m.wd = b; end
                    3: begin m.wr = 1'b1; m.addr = 4'd1; m.wd = b; end
                    default: begin
                        m.ae = 1'b1; m.fun = b[3:0];
                        wait_kind = 2; waited = 0;
                        fq.delete();
                    end
                endcase
            end else if (cmd == CMD_ALU_NOP) begin
                if (fq.size() == 1) begin
                    m.gate = 1'b1;
                end else begin
                    m.ae = 1'b1; m.fun = b[3:0];
                    wait_kind = 2; waited = 0;
                    fq.delete();
                end
            end else begin
                m.err = 1'b1;
                fq.delete();
            end
        end
    endtask

    initial begin
        int got;
        int errs;
        logic v, r, a;
        logic [7:0] d;
        logic [7:0] cmds [4];

        rst = 1'b1;
        bus.RX_D_VLD = 1'b0; bus.RX_P_DATA = '0;
        bus.Rd_data_valid = 1'b0; bus.ALU_OUT_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", mk(0,0,0,0, 4'h0, 8'h00, 4'h0, 0));
        rst = 1'b0;

        // Write frame with 3-cycle gaps
        add(1, 8'hAA, 0, 0, mk(0,0,0,0, 4'h0, 8'h00, 4'h0, 0));
        for (int i = 0; i < 3; i++) add(0, 8'h00, 0, 0, mk(0,0,0,0, 4'h0, 8'h00, 4'h0, 0));
        add(1, 8'h05, 0, 0, mk(0,0,0,0, 4'h0, 8'h00, 4'h0, 0));
        for (int i = 0; i < 3; i++) add(0, 8'h00, 0, 0, mk(0,0,0,0, 4'h0, 8'h00, 4'h0, 0));
        add(1, 8'h3C, 0, 0, mk(1,0,0,0, 4'h5, 8'h3C, 4'h0, 0));
        add(0, 8'h00, 0, 0, mk(0,0,0,0, 4'h5, 8'h3C, 4'h0, 0));
        // Read frame, response 4 cycles after RdEn, then a normal write
        add(1, 8'hBB, 0, 0, mk(0,0,0,0, 4'h5, 8'h3C, 4'h0, 0));
        add(1, 8'h0A, 0, 0, mk(0,1,0,0, 4'hA, 8'h3C, 4'h0, 0));
        for (int i = 0; i < 3; i++) add(0, 8'h00, 0, 0, mk(0,0,0,0, 4'hA, 8'h3C, 4'h0, 0));
        add(0, 8'h00, 1, 0, mk(0,0,0,0, 4'hA, 8'h3C, 4'h0, 0));
        add(1, 8'hAA, 0, 0, mk(0,0,0,0, 4'hA, 8'h3C, 4'h0, 0));
        add(1, 8'h03, 0, 0, mk(0,0,0,0, 4'hA, 8'h3C, 4'h0, 0));
        add(1, 8'h77, 0, 0, mk(1,0,0,0, 4'h3, 8'h77, 4'h0, 0));
        // ALU frame with operands
        add(1, 8'hCC, 0, 0, mk(0,0,0,0, 4'h3, 8'h77, 4'h0, 1));
        add(1, 8'h12, 0, 0, mk(1,0,0,0, 4'h0, 8'h12, 4'h0, 1));
        add(1, 8'h34, 0, 0, mk(1,0,0,0, 4'h1, 8'h34, 4'h0, 1));
        add(1, 8'h02, 0, 0, mk(0,0,1,0, 4'h1, 8'h34, 4'h2, 1));
        add(0, 8'h00, 0, 0, mk(0,0,0,0, 4'h1, 8'h34, 4'h2, 1));
        add(0, 8'h00, 0, 0, mk(0,0,0,0, 4'h1, 8'h34, 4'h2, 1));
        add(0, 8'h00, 0, 1, mk(0,0,0,0, 4'h1, 8'h34, 4'h2, 0));
        // Unknown command, bytes dropped in RD_WAIT, coincident byte+response
        add(1, 8'h55, 0, 0, mk(0,0,0,1, 4'h1, 8'h34, 4'h2, 0));
        add(1, 8'hBB, 0, 0, mk(0,0,0,0, 4'h1, 8'h34, 4'h2, 0));
        add(1, 8'h09, 0, 0, mk(0,1,0,0, 4'h9, 8'h34, 4'h2, 0));
        add(1, 8'h11, 0, 0, mk(0,0,0,1, 4'h9, 8'h34, 4'h2, 0));
        add(0, 8'h00, 1, 0, mk(0,0,0,0, 4'h9, 8'h34, 4'h2, 0));
        add(1, 8'hBB, 0, 0, mk(0,0,0,0, 4'h9, 8'h34, 4'h2, 0));
        add(1, 8'h06, 0, 0, mk(0,1,0,0, 4'h6, 8'h34, 4'h2, 0));
        add(1, 8'hAB, 1, 0, mk(0,0,0,1, 4'h6, 8'h34, 4'h2, 0));
        add(1, 8'hAA, 0, 0, mk(0,0,0,0, 4'h6, 8'h34, 4'h2, 0));
        add(1, 8'h04, 0, 0, mk(0,0,0,0, 4'h6, 8'h34, 4'h2, 0));
        add(1, 8'hEE, 0, 0, mk(1,0,0,0, 4'h4, 8'hEE, 4'h2, 0));
        // Responses outside a wait state are ignored
        add(0, 8'h00, 1, 1, mk(0,0,0,0, 4'h4, 8'hEE, 4'h2, 0));
        add(1, 8'h55, 0, 0, mk(0,0,0,1, 4'h4, 8'hEE, 4'h2, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].vld, tbl[i].data, tbl[i].rdv, tbl[i].aluv);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // ALU without operands and no result: timeout after TIMEOUT cycles
        step(1, 8'hDD, 0, 0);
        check("t4_dd", mk(0,0,0,0, 4'h4, 8'hEE, 4'h2, 1));
        step(1, 8'h07, 0, 0);
        check("t4_alu_en", mk(0,0,1,0, 4'h4, 8'hEE, 4'h7, 1));
        got = -1;
        for (int n = 1; n <= TIMEOUT + 4; n++) begin
            step(0, 8'h00, 0, 0);
            if (bus.Cmd_err === 1'b1) begin
                got = n;
                break;
            end
        end
        check_int("t4_timeout_cycles", got, TIMEOUT);
        check("t4_timeout_err", mk(0,0,0,1, 4'h4, 8'hEE, 4'h7, 0));
        step(1, 8'hBB, 0, 0);
        step(1, 8'h02, 0, 0);
        check("t4_rd_after", mk(0,1,0,0, 4'h2, 8'hEE, 4'h7, 0));
        step(0, 8'h00, 1, 0);
        check("t4_rd_done", mk(0,0,0,0, 4'h2, 8'hEE, 4'h7, 0));

        // Result arriving exactly on the timeout cycle counts as success
        step(1, 8'hDD, 0, 0);
        step(1, 8'h03, 0, 0);
        check("edge_alu_en", mk(0,0,1,0, 4'h2, 8'hEE, 4'h3, 1));
        errs = 0;
        for (int n = 1; n < TIMEOUT; n++) begin
            step(0, 8'h00, 0, 0);
            if (bus.Cmd_err !== 1'b0 || bus.CLK_GATE_EN !== 1'b1) errs++;
        end
        check_int("edge_wait_quiet", errs, 0);
        step(0, 8'h00, 0, 1);
        check("edge_resp_wins", mk(0,0,0,0, 4'h2, 8'hEE, 4'h3, 0));
        step(1, 8'h55, 0, 0);
        check("edge_back_idle", mk(0,0,0,1, 4'h2, 8'hEE, 4'h3, 0));

        // Asynchronous reset mid-frame
        step(1, 8'hAA, 0, 0);
        step(1, 8'h05, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst", mk(0,0,0,0, 4'h0, 8'h00, 4'h0, 0));
        @(posedge CLK);
        #1 rst = 1'b0;
        step(1, 8'h3C, 0, 0);
        check("post_rst_3c", mk(0,0,0,1, 4'h0, 8'h00, 4'h0, 0));
        step(0, 8'h00, 0, 0);
        check("post_rst_idle", mk(0,0,0,0, 4'h0, 8'h00, 4'h0, 0));

        // Random traffic against the frame model
        cmds[0] = CMD_WR; cmds[1] = CMD_RD; cmds[2] = CMD_ALU_OP; cmds[3] = CMD_ALU_NOP;
        rst = 1'b1;
        @(posedge CLK);
        #1 rst = 1'b0;
        model_reset();
        for (int c = 0; c < 5000; c++) begin
            v = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) < 2) d = cmds[$urandom_range(0, 3)];
            else d = 8'($urandom_range(0, 255));
            if (c < 2500) begin
                r = ($urandom_range(0, 15) == 0);
                a = ($urandom_range(0, 15) == 0);
            end else begin
                r = ($urandom_range(0, 399) == 0);
                a = ($urandom_range(0, 399) == 0);
            end
            model_step(v, d, r, a);
            step(v, d, r, a);
            check($sformatf("rand%0d", c), m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
